// File: rtl/lvds_word_aligner_if.sv
// Bus between the ISERDES capture side and the word aligner.
// It carries the raw serial bits in, and the aligned words and sync status out.
interface lvds_word_aligner_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned IN_BITS    = 4
);
    logic [IN_BITS-1:0]    din;
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] pixel_data;
    logic                  pixel_data_valid;
    logic                  receiver_locked;
    logic                  frame_start;
    logic                  frame_end;
    logic                  line_start;
    logic                  line_end;
    logic                  in_frame;
    logic                  in_line;
    logic                  sync_error;
    logic [7:0]            slip_count;

    modport master (
        output din, din_valid,
        input  pixel_data, pixel_data_valid, receiver_locked,
        input  frame_start, frame_end, line_start, line_end,
        input  in_frame, in_line, sync_error, slip_count
    );

    modport slave (
        input  din, din_valid,
        output pixel_data, pixel_data_valid, receiver_locked,
        output frame_start, frame_end, line_start, line_end,
        output in_frame, in_line, sync_error, slip_count
    );
endinterface

// File: rtl/lvds_word_aligner.sv
// Word aligner for the RxClkDiv domain: a gearbox that finds start/stop framing by
// bit-slipping, tracks lock, and decodes and strips embedded frame/line sync words.
module lvds_word_aligner #(
    parameter int unsigned DATA_WIDTH         = 10,
    parameter int unsigned IN_BITS            = 4,
    parameter int unsigned LOCK_COUNT         = 16,
    parameter int unsigned LOSS_COUNT         = 4,
    parameter bit          USE_EMBEDDED_SYNCS = 1'b1
) (
    input  logic                RxClkDiv,
    input  logic                Reset,
    lvds_word_aligner_if.slave  bus
);
    localparam int unsigned FRAME_LEN = DATA_WIDTH + 2;
    localparam int unsigned BUF_W     = FRAME_LEN + IN_BITS;
    localparam int unsigned FILL_W    = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [BUF_W-1:0]      bit_buf, buf_nxt;
    logic [FILL_W-1:0]     fill, fill_nxt, consumed, kept;
    logic [7:0]            good_cnt, good_nxt, bad_cnt, bad_nxt, slip_cnt, slip_nxt;
    logic [FRAME_LEN-1:0]  frame;
    logic [DATA_WIDTH-1:0] word;
    logic                  frame_ok, have_frame, slip_req, do_eval;
    logic                  deliver, drop_lock, armed;

    assign frame      = bit_buf[FRAME_LEN-1:0];
    assign word       = frame[DATA_WIDTH:1];
    assign frame_ok   = frame[0] & ~frame[FRAME_LEN-1];
    assign have_frame = fill >= FILL_W'(FRAME_LEN);
    assign slip_req   = have_frame && !frame_ok && (state != LOCKED);
    // A slip needs one bit past the frame; until it arrives the frame is simply held.
    assign do_eval    = have_frame && (!slip_req || (fill >= FILL_W'(FRAME_LEN + 1)));

    // Next-state: alignment FSM, counters and gearbox bookkeeping.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        slip_nxt  = slip_cnt;
        deliver   = 1'b0;
        drop_lock = 1'b0;
        consumed  = '0;
        if (do_eval) begin
            if (slip_req) begin
                consumed  = FILL_W'(FRAME_LEN + 1);
                state_nxt = HUNT;
                good_nxt  = '0;
                if (slip_cnt != 8'hFF) slip_nxt = slip_cnt + 8'd1;
            end else begin
                consumed = FILL_W'(FRAME_LEN);
                case (state)
                    HUNT, VERIFY: begin
                        good_nxt  = good_cnt + 8'd1;
                        state_nxt = VERIFY;
                        if (good_cnt + 8'd1 >= 8'(LOCK_COUNT)) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                            slip_nxt  = '0;
                        end
                    end
                    default: begin
                        if (frame_ok) begin
                            bad_nxt = '0;
                            deliver = 1'b1;
                        end else if (bad_cnt + 8'd1 >= 8'(LOSS_COUNT)) begin
                            state_nxt = HUNT;
                            good_nxt  = '0;
                            bad_nxt   = '0;
                            drop_lock = 1'b1;
                        end else begin
                            bad_nxt = bad_cnt + 8'd1;
                            deliver = 1'b1;
                        end
                    end
                endcase
            end
        end
        kept     = fill - consumed;
        buf_nxt  = bit_buf >> consumed;
        fill_nxt = kept;
        if (bus.din_valid) begin
            buf_nxt  = buf_nxt | (BUF_W'(bus.din) << kept);
            fill_nxt = kept + FILL_W'(IN_BITS);
        end
    end

    always_ff @(posedge RxClkDiv or posedge Reset) begin
        if (Reset) begin
            state    <= HUNT;
            bit_buf  <= '0;
            fill     <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            slip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            bit_buf  <= buf_nxt;
            fill     <= fill_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            slip_cnt <= slip_nxt;
        end
    end

    assign bus.slip_count = slip_cnt;

    // Output stage: pixel delivery and the marker/code sync decoder.
    always_ff @(posedge RxClkDiv or posedge Reset) begin
        if (Reset) begin
            bus.pixel_data       <= '0;
            bus.pixel_data_valid <= 1'b0;
            bus.receiver_locked  <= 1'b0;
            bus.frame_start      <= 1'b0;
            bus.frame_end        <= 1'b0;
            bus.line_start       <= 1'b0;
            bus.line_end         <= 1'b0;
            bus.in_frame         <= 1'b0;
            bus.in_line          <= 1'b0;
            bus.sync_error       <= 1'b0;
            armed                <= 1'b0;
        end else begin
            bus.pixel_data_valid <= 1'b0;
            bus.frame_start      <= 1'b0;
            bus.frame_end        <= 1'b0;
            bus.line_start       <= 1'b0;
            bus.line_end         <= 1'b0;
            bus.sync_error       <= 1'b0;
            bus.receiver_locked  <= (state_nxt == LOCKED);
            if (drop_lock) begin
                bus.in_frame <= 1'b0;
                bus.in_line  <= 1'b0;
                armed        <= 1'b0;
            end else if (deliver) begin
                if (USE_EMBEDDED_SYNCS && armed) begin
                    armed <= 1'b0;
                    case (word)
                        DATA_WIDTH'(0): begin
                            bus.frame_start <= 1'b1;
                            bus.in_frame    <= 1'b1;
                        end
                        DATA_WIDTH'(1): begin
                            bus.frame_end <= 1'b1;
                            bus.in_frame  <= 1'b0;
                            bus.in_line   <= 1'b0;
                        end
                        DATA_WIDTH'(2): begin
                            bus.line_start <= 1'b1;
                            bus.in_line    <= 1'b1;
                        end
                        DATA_WIDTH'(3): begin
                            bus.line_end <= 1'b1;
                            bus.in_line  <= 1'b0;
                        end
                        default: bus.sync_error <= 1'b1;
                    endcase
                end else if (USE_EMBEDDED_SYNCS && (&word)) begin
                    armed <= 1'b1;
                end else begin
                    bus.pixel_data_valid <= 1'b1;
                    bus.pixel_data       <= word;
                end
            end
        end
    end
endmodule

// File: tb/tb_lvds_word_aligner.sv
// Self-checking bench for lvds_word_aligner: directed lock/sync/loss sequences, a sync
// decode vector table, and randomized streams compared against a bit-queue reference model.
module tb_lvds_word_aligner;
    localparam int unsigned DW = 10;
    localparam int unsigned IB = 4;
    localparam int unsigned LC = 4;
    localparam int unsigned LS = 2;
    localparam int unsigned FL = DW + 2;
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lvds_word_aligner_if #(.DATA_WIDTH(DW), .IN_BITS(IB)) bus ();

    lvds_word_aligner #(
        .DATA_WIDTH(DW), .IN_BITS(IB), .LOCK_COUNT(LC), .LOSS_COUNT(LS),
        .USE_EMBEDDED_SYNCS(1'b1)
    ) dut (
        .RxClkDiv(clk),
        .Reset(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: buffered bits as a queue, spec rules applied per cycle.
    bit          mq[$];
    int          m_mode, m_good, m_bad, m_slips;
    bit          m_armed, m_if, m_il;
    bit          e_locked, e_pdv, e_fs, e_fe, e_ls, e_le, e_err;
    logic [DW-1:0] e_pix;

    bit          txq[$];
    logic [DW-1:0] got_pix[$];
    int          acc_pdv;
    logic [DW-1:0] acc_pix;
    logic [4:0]  acc_pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] dut_vec();
        return {bus.receiver_locked, bus.pixel_data_valid, bus.pixel_data,
                bus.frame_start, bus.frame_end, bus.line_start, bus.line_end,
                bus.in_frame, bus.in_line, bus.sync_error, bus.slip_count};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {e_locked, e_pdv, e_pix, e_fs, e_fe, e_ls, e_le, m_if, m_il, e_err, 8'(m_slips)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = M_HUNT; m_good = 0; m_bad = 0; m_slips = 0;
        m_armed = 0; m_if = 0; m_il = 0;
        e_locked = 0; e_pdv = 0; e_fs = 0; e_fe = 0; e_ls = 0; e_le = 0; e_err = 0;
        e_pix = '0;
    endtask

    task automatic model_deliver(input int w);
        if (m_armed) begin
            m_armed = 0;
            case (w)
                0: begin e_fs = 1; m_if = 1; end
                1: begin e_fe = 1; m_if = 0; m_il = 0; end
                2: begin e_ls = 1; m_il = 1; end
                3: begin e_le = 1; m_il = 0; end
                default: e_err = 1;
            endcase
        end else if (w == (1 << DW) - 1) begin
            m_armed = 1;
        end else begin
            e_pdv = 1;
            e_pix = DW'(w);
        end
    endtask

    task automatic model_step(input bit valid, input logic [IB-1:0] d);
        int w;
        bit ok;
        e_pdv = 0; e_fs = 0; e_fe = 0; e_ls = 0; e_le = 0; e_err = 0;
        if (mq.size() >= FL) begin
            w = 0;
            for (int i = 0; i < DW; i++) if (mq[1 + i]) w += (1 << i);
            ok = (mq[0] == 1'b1) && (mq[FL - 1] == 1'b0);
            if (!ok && m_mode != M_LOCKED) begin
                if (mq.size() >= FL + 1) begin
                    for (int i = 0; i <= FL; i++) void'(mq.pop_front());
                    m_mode = M_HUNT; m_good = 0;
                    m_slips = (m_slips < 255) ? m_slips + 1 : 255;
                end
            end else begin
                for (int i = 0; i < FL; i++) void'(mq.pop_front());
                if (m_mode != M_LOCKED) begin
                    m_good++;
                    if (m_good >= LC) begin m_mode = M_LOCKED; m_bad = 0; m_slips = 0; end
                    else m_mode = M_VERIFY;
                end else if (ok) begin
                    m_bad = 0;
                    model_deliver(w);
                end else begin
                    m_bad++;
                    if (m_bad >= LS) begin
                        m_mode = M_HUNT; m_good = 0; m_bad = 0;
                        m_if = 0; m_il = 0; m_armed = 0;
                    end else model_deliver(w);
                end
            end
        end
        if (valid) for (int i = 0; i < IB; i++) mq.push_back(d[i]);
        e_locked = (m_mode == M_LOCKED);
    endtask

    // One clock: drive, advance the model, sample #1 after the edge and compare.
    task automatic step(input bit valid);
        logic [IB-1:0] d;
        d = IB'($urandom);
        if (valid) for (int i = 0; i < IB; i++) d[i] = (txq.size() > 0) ? txq.pop_front() : 1'b0;
        bus.din = d;
        bus.din_valid = valid;
        model_step(valid, d);
        @(posedge clk);
        #1;
        check("model", 32'(dut_vec()), 32'(exp_vec()));
        if (bus.pixel_data_valid) begin
            acc_pdv++;
            acc_pix = bus.pixel_data;
            got_pix.push_back(bus.pixel_data);
        end
        acc_pulses |= {bus.frame_start, bus.frame_end, bus.line_start, bus.line_end, bus.sync_error};
    endtask

    task automatic push_frame(input bit start, input logic [DW-1:0] w, input bit stop);
        txq.push_back(start);
        for (int i = 0; i < DW; i++) txq.push_back(w[i]);
        txq.push_back(stop);
    endtask

    // Send one aligned frame and let it be evaluated and output.
    task automatic send_one(input bit start, input logic [DW-1:0] w, input bit stop);
        acc_pdv = 0; acc_pix = '0; acc_pulses = '0;
        push_frame(start, w, stop);
        repeat (3) step(1'b1);
        repeat (2) step(1'b0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        bus.din_valid = 1'b0;
        model_reset();
        txq.delete();
        #1;
        check("reset_async", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound, input bit random_valid);
        int n;
        n = 0;
        while (txq.size() > 0 && n < bound) begin
            step(random_valid ? 1'($urandom) : 1'b1);
            n++;
        end
        check({tag, "_drained"}, 32'(txq.size()), 32'd0);
        txq.delete();
    endtask

    task automatic relock_check(input string tag);
        int lstep;
        lstep = -1;
        got_pix.delete();
        push_frame(1, 10'h155, 0); push_frame(1, 10'h2AA, 0);
        push_frame(1, 10'h155, 0); push_frame(1, 10'h2AA, 0);
        push_frame(1, 10'h0F0, 0);
        for (int s = 1; s <= 17; s++) begin
            step(s <= 15);
            if (lstep < 0 && bus.receiver_locked) lstep = s;
        end
        check({tag, "_lock_step"}, 32'(lstep), 32'd13);
        check({tag, "_npix"}, 32'(got_pix.size()), 32'd1);
        if (got_pix.size() > 0) check({tag, "_pix"}, 32'(got_pix[0]), 32'h0F0);
    endtask

    typedef struct {
        logic [DW-1:0] word;
        int            n_pix;
        logic [DW-1:0] pix;
        logic [4:0]    pulses;  // {frame_start, frame_end, line_start, line_end, sync_error}
        bit            inf;
        bit            inl;
    } vec_t;

    vec_t tbl[21];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   lstep, max_slip, seen_lock, slip_after;
        logic [DW-1:0] sent[$];
        logic [DW-1:0] w;

        tbl[0]  = '{10'h010, 1, 10'h010, 5'b00000, 1'b0, 1'b0};
        tbl[1]  = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b0, 1'b0};
        tbl[2]  = '{10'h000, 0, 10'h000, 5'b10000, 1'b1, 1'b0};
        tbl[3]  = '{10'h010, 1, 10'h010, 5'b00000, 1'b1, 1'b0};
        tbl[4]  = '{10'h020, 1, 10'h020, 5'b00000, 1'b1, 1'b0};
        tbl[5]  = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b1, 1'b0};
        tbl[6]  = '{10'h002, 0, 10'h000, 5'b00100, 1'b1, 1'b1};
        tbl[7]  = '{10'h123, 1, 10'h123, 5'b00000, 1'b1, 1'b1};
        tbl[8]  = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b1, 1'b1};
        tbl[9]  = '{10'h003, 0, 10'h000, 5'b00010, 1'b1, 1'b0};
        tbl[10] = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b1, 1'b0};
        tbl[11] = '{10'h007, 0, 10'h000, 5'b00001, 1'b1, 1'b0};
        tbl[12] = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b1, 1'b0};
        tbl[13] = '{10'h3FF, 0, 10'h000, 5'b00001, 1'b1, 1'b0};
        tbl[14] = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b1, 1'b0};
        tbl[15] = '{10'h001, 0, 10'h000, 5'b01000, 1'b0, 1'b0};
        tbl[16] = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b0, 1'b0};
        tbl[17] = '{10'h002, 0, 10'h000, 5'b00100, 1'b0, 1'b1};
        tbl[18] = '{10'h3FF, 0, 10'h000, 5'b00000, 1'b0, 1'b1};
        tbl[19] = '{10'h001, 0, 10'h000, 5'b01000, 1'b0, 1'b0};
        tbl[20] = '{10'h155, 1, 10'h155, 5'b00000, 1'b0, 1'b0};

        bus.din = '0;
        bus.din_valid = 1'b0;
        acc_pdv = 0; acc_pix = '0; acc_pulses = '0;

        // Junk-prefixed stream: five zero bits ahead of the 0x155/0x2AA pattern.
        do_reset();
        got_pix.delete();
        max_slip = 0; seen_lock = 0; slip_after = -1;
        for (int i = 0; i < 5; i++) txq.push_back(1'b0);
        for (int k = 0; k < 20; k++) push_frame(1, (k % 2) ? 10'h2AA : 10'h155, 0);
        for (int n = 0; n < 300 && txq.size() > 0; n++) begin
            step(1'b1);
            if (!bus.receiver_locked && int'(bus.slip_count) > max_slip) max_slip = int'(bus.slip_count);
            if (bus.receiver_locked && !seen_lock) begin
                seen_lock = 1;
                slip_after = int'(bus.slip_count);
            end
        end
        repeat (2) step(1'b0);
        check("junk_slips", 32'(max_slip), 32'd5);
        check("junk_locked", 32'(seen_lock), 32'd1);
        check("junk_slip_cleared", 32'(slip_after), 32'd0);
        check("junk_pix0", 32'(got_pix.size() > 0 ? got_pix[0] : 10'h3FF), 32'h2AA);
        check("junk_pix1", 32'(got_pix.size() > 1 ? got_pix[1] : 10'h3FF), 32'h155);

        // Aligned stream: lock after the 4th frame, 5th word is the first pixel.
        do_reset();
        got_pix.delete();
        lstep = -1;
        for (int k = 0; k < 8; k++) push_frame(1, (k % 2) ? 10'h2AA : 10'h155, 0);
        for (int s = 1; s <= 26; s++) begin
            step(s <= 24);
            if (lstep < 0 && bus.receiver_locked) lstep = s;
        end
        check("aligned_lock_step", 32'(lstep), 32'd13);
        check("aligned_slips", 32'(bus.slip_count), 32'd0);
        check("aligned_npix", 32'(got_pix.size()), 32'd4);
        check("aligned_pix0", 32'(got_pix.size() > 0 ? got_pix[0] : 10'h3FF), 32'h155);
        check("aligned_pix1", 32'(got_pix.size() > 1 ? got_pix[1] : 10'h3FF), 32'h2AA);

        // Sync decode vector table, one aligned word per entry while locked.
        for (int i = 0; i < 21; i++) begin
            send_one(1'b1, tbl[i].word, 1'b0);
            check($sformatf("tbl%0d_npix", i), 32'(acc_pdv), 32'(tbl[i].n_pix));
            if (tbl[i].n_pix > 0) check($sformatf("tbl%0d_pix", i), 32'(acc_pix), 32'(tbl[i].pix));
            check($sformatf("tbl%0d_pulses", i), 32'(acc_pulses), 32'(tbl[i].pulses));
            check($sformatf("tbl%0d_in_frame", i), 32'(bus.in_frame), 32'(tbl[i].inf));
            check($sformatf("tbl%0d_in_line", i), 32'(bus.in_line), 32'(tbl[i].inl));
        end

        // Lock loss: one bad stop bit is tolerated, two consecutive bad frames drop lock.
        send_one(1'b1, 10'h3FF, 1'b0);
        send_one(1'b1, 10'h000, 1'b0);
        check("loss_in_frame_set", 32'(bus.in_frame), 32'd1);
        send_one(1'b1, 10'h0AB, 1'b1);
        check("loss_badstop_npix", 32'(acc_pdv), 32'd1);
        check("loss_badstop_pix", 32'(acc_pix), 32'h0AB);
        check("loss_badstop_locked", 32'(bus.receiver_locked), 32'd1);
        send_one(1'b1, 10'h011, 1'b0);
        send_one(1'b0, 10'h022, 1'b0);
        check("loss_bad1_pix", 32'(acc_pix), 32'h022);
        check("loss_bad1_locked", 32'(bus.receiver_locked), 32'd1);
        send_one(1'b0, 10'h033, 1'b0);
        check("loss_bad2_npix", 32'(acc_pdv), 32'd0);
        check("loss_bad2_locked", 32'(bus.receiver_locked), 32'd0);
        check("loss_bad2_in_frame", 32'(bus.in_frame), 32'd0);

        // Relock, then a 50% din_valid stream must come out unchanged apart from gaps.
        relock_check("relock1");
        got_pix.delete();
        sent.delete();
        for (int k = 0; k < 30; k++) begin
            w = DW'($urandom_range(0, 1022));
            sent.push_back(w);
            push_frame(1, w, 0);
        end
        drain("gaps", 1000, 1'b1);
        repeat (3) step(1'b0);
        check("gaps_npix", 32'(got_pix.size()), 32'(sent.size()));
        for (int i = 0; i < sent.size(); i++)
            if (i < got_pix.size()) check($sformatf("gaps_pix%0d", i), 32'(got_pix[i]), 32'(sent[i]));

        // Reset in the middle of a word, then a clean relock.
        for (int k = 0; k < 3; k++) push_frame(1, 10'h0C3, 0);
        repeat (5) step(1'b1);
        do_reset();
        relock_check("relock2");

        // Randomized streams: random junk prefix, mixed words, syncs, corruption and gaps.
        for (int r = 0; r < 6; r++) begin
            int junk;
            do_reset();
            junk = $urandom_range(0, 23);
            for (int i = 0; i < junk; i++) txq.push_back(1'($urandom));
            for (int k = 0; k < 40; k++) begin
                int sel;
                sel = $urandom_range(0, 15);
                if (sel < 2) w = 10'h3FF;
                else if (sel < 4) w = DW'($urandom_range(0, 4));
                else w = DW'($urandom);
                if (sel == 15) push_frame(1'($urandom), w, 1'b1);
                else push_frame(1, w, 0);
            end
            begin
                int n;
                n = 0;
                while (txq.size() > 0 && n < 2000) begin
                    step(($urandom % 4) != 0);
                    n++;
                end
                check($sformatf("rand%0d_drained", r), 32'(txq.size()), 32'd0);
            end
            repeat (3) step(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lvds_word_aligner.md
Name: lvds_word_aligner

Overview:
- Parametrised successor to the fixed camera deserializer datapath: a generic word aligner and embedded-sync decoder.
- Sits in the RxClkDiv domain, directly after the ISERDES bit capture. Takes IN_BITS raw serial bits per cycle and finds start/stop framing by bit-slipping.
- Emits aligned DATA_WIDTH pixel words with lock status.
- Optionally strips and decodes embedded frame/line sync codes so downstream video logic needs no separate sync wires.

Parameters:
- DATA_WIDTH, 10, payload bits per word (4..16); FRAME_LEN = DATA_WIDTH+2.
- IN_BITS, 4, serial bits delivered per cycle (1..FRAME_LEN).
- LOCK_COUNT, 16, consecutive good frames needed to declare lock (1..255).
- LOSS_COUNT, 4, consecutive bad frames that drop lock (1..255).
- USE_EMBEDDED_SYNCS, 1, 1 = decode and strip sync marker words; 0 = pass all words.

Ports:
- RxClkDiv  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- din  in  IN_BITS  serial bits; din[0] is the earliest received.
- din_valid  in  1  din is meaningful this cycle.
- pixel_data  out  DATA_WIDTH  aligned payload.
- pixel_data_valid  out  1  one-cycle qualifier for pixel_data.
- receiver_locked  out  1  alignment lock.
- frame_start, frame_end, line_start, line_end  out  1 each  one-cycle sync pulses.
- in_frame, in_line  out  1 each  level flags.
- sync_error  out  1  one-cycle pulse on an unknown sync code.
- slip_count  out  8  saturating count of bit slips since the last lock.

Behaviour:
- Reset: all outputs 0; bit buffer empty (fill=0); state HUNT; all counters 0.
- Gearbox:
  - Buffer width FRAME_LEN+IN_BITS. On din_valid, din is appended above the current fill.
  - A frame is evaluated when fill >= FRAME_LEN (at most one per cycle).
  - Frame bit0 = start (must be 1), bits 1..DATA_WIDTH = data LSB first, bit FRAME_LEN-1 = stop (must be 0).
  - Normal consume removes FRAME_LEN bits.
  - Slip removes FRAME_LEN+1 bits and requires fill >= FRAME_LEN+1; otherwise the slip waits, with no evaluation that cycle.
  - Append and consume in the same cycle are legal; new fill = fill + IN_BITS·din_valid − consumed.
- State machine:
  - HUNT: bad frame -> slip, good=0, slip_count+1 (saturates at 255). Good frame -> VERIFY, good=1.
  - VERIFY: good frame -> good+1; when good reaches LOCK_COUNT -> LOCKED, receiver_locked=1, slip_count cleared. Bad frame -> HUNT with slip.
  - LOCKED: bad frame -> bad+1. Good frame -> bad=0. bad reaching LOSS_COUNT -> HUNT, receiver_locked=0 the next cycle, in_frame/in_line cleared, no slip on that transition.
- Output timing:
  - Frames are delivered only in LOCKED, including bad frames below the loss threshold (data passed as-is).
  - Latency: registered, 1 cycle after the evaluation cycle.
- Embedded syncs (USE_EMBEDDED_SYNCS=1, LOCKED only):
  - Word = all-ones is a marker: not output, arms the code decoder.
  - Next word is the code:
    - 0 -> frame_start, in_frame=1.
    - 1 -> frame_end, in_frame=0, in_line=0.
    - 2 -> line_start, in_line=1.
    - 3 -> line_end, in_line=0.
    - other -> sync_error, state unchanged.
  - The code word is never output.
  - Marker followed by marker: the second is treated as a code (value all-ones) -> sync_error.
  - Lock loss between marker and code: decoder disarmed.
  - With USE_EMBEDDED_SYNCS=0, every locked word is output and all sync outputs stay 0.
- din_valid=0: no append; a frame still evaluates if enough buffered bits remain.
- Mid-operation reset clears everything asynchronously; no partial word is emitted afterwards.

Test Plan (DATA_WIDTH=10, IN_BITS=4, LOCK_COUNT=4, LOSS_COUNT=2):
- Aligned stream of words 0x155, 0x2AA repeated -> receiver_locked rises after the 4th good frame; first pixel_data_valid carries the 5th word; slip_count=0.
- Same stream prefixed with 5 junk bits -> exactly 5 slips (mod FRAME_LEN); lock acquired; correct word sequence; slip_count cleared at lock.
- Locked, then 1 frame with stop bit=1 -> word still output, lock held. Then 2 consecutive bad frames -> receiver_locked=0, in_frame=0.
- Marker 0x3FF, code 0; pixels 0x010, 0x020; marker, code 2 -> frame_start pulse, in_frame=1, exactly two pixel_data_valid pulses, then line_start, in_line=1; no 0x3FF is output.
- Marker then code 7 -> sync_error pulse, in_frame/in_line unchanged, no pixel output for either word.
- din_valid toggled 50% during a locked stream, then Reset asserted mid-word -> output sequence identical minus gaps; after reset all outputs 0, state HUNT, relock after 4 good frames.
